// File: rtl/cic_pkg.sv
// Shared sizing helpers for the CIC decimator: clog2, accumulator width, ratio-field width.
// Pure constant functions; no logic, no latency.
package cic_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  // Hogenauer bit growth: N stages of gain R*M each on top of the input width.
  function automatic int acc_width(input int in_w, input int n, input int rmax, input int m);
    return in_w + n * clog2(rmax * m);
  endfunction

  function automatic int ratio_width(input int rmax);
    return (clog2(rmax) < 1) ? 1 : clog2(rmax);
  endfunction

endpackage

// File: rtl/cic_comb_stage.sv
// One CIC comb (differentiator) section, y = x - x delayed by M valid events; 1 cycle latency.
// No backpressure: acts only on in_valid, delay line holds otherwise.
module cic_comb_stage #(
  parameter int W = 16,
  parameter int M = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  logic [W-1:0] dly [M];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < M; i++) dly[i] <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data - dly[M-1];
        dly[0]   <= in_data;
        for (int i = 1; i < M; i++) dly[i] <= dly[i-1];
      end
    end
  end

endmodule

// File: rtl/cic_decimator.sv
// Parametrised CIC decimator on a single clock; out_valid N+1 clocks after the R-th accepted sample.
// No backpressure: accepts one sample per in_valid, emits a one-cycle out_valid pulse per block.
module cic_decimator
  import cic_pkg::*;
#(
  parameter int IN_W      = 1,
  parameter int IN_SIGNED = 0,
  parameter int N         = 3,
  parameter int RMAX      = 16,
  parameter int M         = 1,
  parameter int ACC_W     = acc_width(IN_W, N, RMAX, M),
  parameter int OUT_W     = ACC_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [IN_W-1:0]               in_data,
  input  logic [ratio_width(RMAX)-1:0]  dec_ratio_m1,
  output logic                          out_valid,
  output logic [OUT_W-1:0]              out_data
);

  localparam int RW = ratio_width(RMAX);

  logic [ACC_W-1:0] x_ext;
  logic [ACC_W-1:0] integ     [N];
  logic [ACC_W-1:0] integ_nxt [N];
  logic [RW-1:0]    cnt;
  logic [RW-1:0]    r_act;
  logic [ACC_W-1:0] comb_in;
  logic             comb_in_valid;

  logic [N:0][ACC_W-1:0] c_dat;
  logic [N:0]            c_vld;

  always_comb begin
    if (IN_SIGNED != 0) x_ext = ACC_W'($signed(in_data));
    else                x_ext = ACC_W'(in_data);
  end

  // Each integrator adds the previous stage's registered (old) value; wrap is intentional.
  always_comb begin
    integ_nxt[0] = integ[0] + x_ext;
    for (int k = 1; k < N; k++) integ_nxt[k] = integ[k] + integ[k-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++) integ[k] <= '0;
      cnt           <= '0;
      r_act         <= dec_ratio_m1;
      comb_in       <= '0;
      comb_in_valid <= 1'b0;
    end else begin
      comb_in_valid <= 1'b0;
      if (in_valid) begin
        for (int k = 0; k < N; k++) integ[k] <= integ_nxt[k];
        if (cnt == r_act) begin
          // Block boundary: new ratio only takes effect here so blocks are never split.
          cnt           <= '0;
          r_act         <= dec_ratio_m1;
          comb_in       <= integ_nxt[N-1];
          comb_in_valid <= 1'b1;
        end else begin
          cnt <= cnt + RW'(1);
        end
      end
    end
  end

  assign c_dat[0] = comb_in;
  assign c_vld[0] = comb_in_valid;

  for (genvar k = 0; k < N; k++) begin : g_comb
    cic_comb_stage #(
      .W (ACC_W),
      .M (M)
    ) u_comb (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (c_vld[k]),
      .in_data   (c_dat[k]),
      .out_valid (c_vld[k+1]),
      .out_data  (c_dat[k+1])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      out_valid <= c_vld[N];
      if (c_vld[N]) out_data <= c_dat[N][ACC_W-1 -: OUT_W];
    end
  end

endmodule

// File: tb/tb_cic_decimator.sv
// Directed bench for cic_decimator: default config plus an 8-bit signed N=4 instance.
module tb_cic_decimator;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [0:0]  in_data = 1'b0;
  logic [3:0]  dec_ratio_m1 = 4'd15;
  logic        out_valid;
  logic [12:0] out_data;

  logic        in8_valid = 1'b0;
  logic [7:0]  in8_data = 8'd0;
  logic [2:0]  ratio8 = 3'd7;
  logic        out8_valid;
  logic [19:0] out8_data;

  cic_decimator dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .dec_ratio_m1 (dec_ratio_m1),
    .out_valid    (out_valid),
    .out_data     (out_data)
  );

  cic_decimator #(
    .IN_W      (8),
    .IN_SIGNED (1),
    .N         (4),
    .RMAX      (8),
    .M         (1)
  ) dut8 (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in8_valid),
    .in_data      (in8_data),
    .dec_ratio_m1 (ratio8),
    .out_valid    (out8_valid),
    .out_data     (out8_data)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int oq_dat[$];
  int oq_cyc[$];
  int n8 = 0;
  logic [19:0] last8 = '0;
  logic [19:0] prev8 = '0;

  typedef struct {
    int ratio_m1;
    int mode;      // 0: constant 1, 1: single 1 then zeros, 2: all zeros
    bit gapped;
    int spacing;
    int exp_d[4];
  } scen_t;

  scen_t sc[5];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: edge, then sample outputs on the following falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    @(negedge clk);
    if (out_valid === 1'b1) begin
      oq_dat.push_back(int'(out_data));
      oq_cyc.push_back(cyc);
    end
    if (out8_valid === 1'b1) begin
      n8++;
      prev8 = last8;
      last8 = out8_data;
    end
  endtask

  task automatic apply(input logic v, input logic d);
    in_valid   = v;
    in_data[0] = d;
    tick();
  endtask

  task automatic do_reset(input int ratio_m1);
    rst          = 1'b1;
    in_valid     = 1'b0;
    dec_ratio_m1 = 4'(ratio_m1);
    tick();
    rst = 1'b0;
    oq_dat.delete();
    oq_cyc.delete();
  endtask

  initial begin
    int r;
    int acc;
    logic d;
    logic [9:0] pat;

    sc[0] = '{15, 0, 1'b0, 16, '{560, 3280, 4096, 4096}};
    sc[1] = '{15, 2, 1'b0, 16, '{0, 0, 0, 0}};
    sc[2] = '{15, 1, 1'b0, 16, '{105, 150, 1, 0}};
    sc[3] = '{15, 0, 1'b1, 32, '{560, 3280, 4096, 4096}};
    sc[4] = '{7,  0, 1'b0, 8,  '{56, 392, 512, 512}};

    @(negedge clk);
    do_reset(15);
    chk("reset_out_valid", int'(out_valid), 0);
    chk("reset_out_data", int'(out_data), 0);
    chk("reset_out8_valid", int'(out8_valid), 0);

    for (int s = 0; s < 5; s++) begin
      do_reset(sc[s].ratio_m1);
      r   = sc[s].ratio_m1 + 1;
      acc = -1;
      for (int i = 0; i < 4 * r; i++) begin
        d = (sc[s].mode == 0) || (sc[s].mode == 1 && i == 0);
        apply(1'b1, d);
        if (i == r - 1) acc = cyc;
        if (sc[s].gapped) apply(1'b0, d);
      end
      for (int i = 0; i < 8; i++) apply(1'b0, 1'b0);
      chk($sformatf("scen%0d_count", s), oq_dat.size(), 4);
      if (oq_dat.size() >= 4) begin
        for (int j = 0; j < 4; j++)
          chk($sformatf("scen%0d_data%0d", s, j), oq_dat[j], sc[s].exp_d[j]);
        chk($sformatf("scen%0d_latency", s), oq_cyc[0] - acc, 4);
        chk($sformatf("scen%0d_spacing", s), oq_cyc[1] - oq_cyc[0], sc[s].spacing);
        chk($sformatf("scen%0d_spacing_late", s), oq_cyc[3] - oq_cyc[2], sc[s].spacing);
      end
    end

    // Ratio 16 -> 8 requested mid-block: first block still closes at 16 samples.
    do_reset(15);
    acc = -1;
    for (int i = 0; i < 48; i++) begin
      if (i == 5) dec_ratio_m1 = 4'd7;
      apply(1'b1, 1'b1);
      if (i == 15) acc = cyc;
    end
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b0);
    chk("rchg_count", oq_dat.size(), 5);
    if (oq_dat.size() >= 5) begin
      chk("rchg_latency", oq_cyc[0] - acc, 4);
      chk("rchg_spacing", oq_cyc[1] - oq_cyc[0], 8);
      chk("rchg_d0", oq_dat[0], 560);
      chk("rchg_d1", oq_dat[1], 344);
      chk("rchg_d2", oq_dat[2], 568);
      chk("rchg_d3", oq_dat[3], 512);
      chk("rchg_d4", oq_dat[4], 512);
    end

    // R=1: the integrator register chain delays the data by N-1 = 2 samples.
    do_reset(0);
    pat = 10'b00_0100_1101;
    acc = -1;
    for (int i = 0; i < 10; i++) begin
      apply(1'b1, pat[i]);
      if (i == 0) acc = cyc;
    end
    for (int i = 0; i < 6; i++) apply(1'b0, 1'b0);
    chk("r1_count", oq_dat.size(), 10);
    if (oq_dat.size() >= 10) begin
      chk("r1_latency", oq_cyc[0] - acc, 4);
      for (int j = 0; j < 10; j++)
        chk($sformatf("r1_data%0d", j), oq_dat[j], (j >= 2) ? int'(pat[j-2]) : 0);
    end

    // Reset lands on the edge that would have raised out_valid for the first block.
    do_reset(15);
    for (int i = 0; i < 19; i++) apply(1'b1, 1'b1);
    rst      = 1'b1;
    in_valid = 1'b1;
    tick();
    chk("midrst_out_valid", int'(out_valid), 0);
    chk("midrst_out_data", int'(out_data), 0);
    rst = 1'b0;
    oq_dat.delete();
    oq_cyc.delete();
    acc = -1;
    for (int i = 0; i < 64; i++) begin
      apply(1'b1, 1'b1);
      if (i == 15) acc = cyc;
    end
    for (int i = 0; i < 8; i++) apply(1'b0, 1'b0);
    chk("midrst_count", oq_dat.size(), 4);
    if (oq_dat.size() >= 4) begin
      chk("midrst_latency", oq_cyc[0] - acc, 4);
      for (int j = 0; j < 4; j++)
        chk($sformatf("midrst_data%0d", j), oq_dat[j], sc[0].exp_d[j]);
    end

    // Signed 8-bit, N=4, R=8: -128 * 8^4 = -2^19, the most negative 20-bit value.
    in_valid  = 1'b0;
    n8        = 0;
    in8_valid = 1'b1;
    in8_data  = 8'h80;
    for (int i = 0; i < 1000; i++) tick();
    in8_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("dc8_count", n8, 125);
    chk("dc8_last", int'($signed(last8)), -524288);
    chk("dc8_prev", int'($signed(prev8)), -524288);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cic_decimator.md
Name: cic_decimator

Overview:
Parametrised CIC (Hogenauer) decimation filter. Successor to the fixed 3-stage, 19-bit, divided-clock CIC.
- Configurable stage count, input width/signedness, differential delay and maximum ratio.
- Decimation ratio is programmable at run time.
- Runs on one clock with valid qualifiers; no derived clock.
- Sits between the sigma-delta modulator bitstream (or a multi-bit ADC word) and the downstream FIR/compensation stage.

Parameters:
IN_W, 1, input sample width
IN_SIGNED, 0, 1 = two's-complement input (sign-extend), 0 = unsigned (zero-extend)
N, 3, number of integrator and comb stages (1..6)
RMAX, 16, maximum decimation ratio (power of 2, >= 2)
M, 1, comb differential delay (1 or 2)
ACC_W, IN_W + N*clog2(RMAX*M), internal register width (derived; do not override)
OUT_W, ACC_W, output width; output is the top OUT_W bits of ACC_W (truncation)

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
in_valid  in  1  in_data carries a sample this cycle
in_data  in  IN_W  input sample
dec_ratio_m1  in  clog2(RMAX)  decimation ratio minus 1 (R = dec_ratio_m1 + 1)
out_valid  out  1  single-cycle pulse, out_data valid
out_data  out  OUT_W  decimated output sample

Behaviour:
- Reset: clk is the only clock; rst is synchronous and active-high. On a rising clk edge with rst=1, the following clear to 0: integrators, comb delays, comb outputs, valid pipeline, decimation counter, out_valid and out_data. The active ratio register loads dec_ratio_m1.
- Reset mid-operation: all state is discarded. out_valid is 0 in the cycle after the reset edge. Output after release is identical to a fresh start.
- Arithmetic: all adders and subtractors are ACC_W wide with modulo wrap-around. Wrap is intentional and not flagged; CIC correctness relies on it. Input is extended to ACC_W per IN_SIGNED.
- Integrators:
  - Update only on edges where in_valid=1: I1 += x; Ik += I(k-1) (old value), k = 2..N.
  - With in_valid=0 all integrators hold.
- Decimation counter cnt:
  - Counts accepted samples from 0 to R_act-1, where R_act is the active ratio.
  - On an accepted sample with cnt == R_act-1: cnt -> 0, a decimation event fires, and the next value of IN (including this sample) is captured into the comb input with valid.
  - dec_ratio_m1 is sampled into R_act only at that wrap (and at reset), so a mid-block change takes effect from the next block.
  - R_act = 1: every accepted sample fires an event.
- Comb chain: N registered stages. Stage k acts only when its input valid is 1:
  - y_k <= x_k - x_k delayed by M events;
  - the delay line shifts;
  - valid_k <= 1; otherwise valid_k <= 0.
  - Delay lines never advance without valid.
- Output: registered. out_data = y_N[ACC_W-1 -: OUT_W]; out_valid = valid_N.
- Latency: out_valid is high in the cycle N+1 clocks after the edge that accepted the R-th sample. out_data holds its value between pulses.
- Throughput:
  - One input per clock.
  - Output spacing = R_act accepted samples.
  - in_valid gaps only stretch the spacing; values are unchanged.
- Gain is (R*M)^N. Steady DC output = DC_in*(R*M)^N before truncation.

Decomposition:
- Package cic_pkg: clog2 constant function, ACC_W derivation function, ratio-width localparam helper.
- Sub-module cic_comb_stage (params W, M):
  - ports clk, rst, in_valid, in_data, out_valid, out_data;
  - instantiated N times in a generate loop.
- Integrators and counter stay in the top module.

Test Plan:
1. Defaults (IN_W=1, unsigned, N=3, M=1), dec_ratio_m1=15, constant in_data=1, in_valid=1 -> out_valid every 16 cycles; 4th and later out_data = 4096.
2. Same config, in_data=0 throughout -> every out_data = 0. Single 1 followed by zeros -> sum of all out_data = 256 (R^(N-1)), and out_data returns to 0 after 3 outputs.
3. Constant 1 with in_valid toggling 1,0,1,0 -> out_valid every 32 cycles; identical out_data sequence to test 1; latency from the 16th accepted sample = 4 clocks.
4. Change dec_ratio_m1 15 -> 7 mid-block -> the current block completes at 16. Subsequent outputs spaced 8, settling to 512. dec_ratio_m1=0 -> out_data follows in_data with latency 4.
5. IN_W=8, IN_SIGNED=1, N=4, RMAX=8, dec_ratio_m1=7; constant -128 for 1000 samples -> steady out_data = -524288 at ACC_W=20. This exercises integrator wrap with no error.
6. Assert rst for 1 cycle in the middle of a block -> out_valid=0 next cycle; the restarted test-1 sequence matches a fresh run bit-for-bit.
